// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
// Latency: n/a (type/constant definitions only).
// Backpressure: n/a.
package wb_pkg;

    // Width of the saturating contention counter.
    localparam int WB_CNT_W = 16;

    // Default datapath widths used by wb_req_t.
    localparam int WB_DW = 64;
    localparam int WB_AW = 5;

    // Write-back source index; also the encoding of the round-robin pointer.
    typedef enum logic {
        WB_SRC_MEM = 1'b0,
        WB_SRC_ALU = 1'b1
    } wb_src_e;

    // One write-back request as presented by a source.
    typedef struct packed {
        logic             valid;
        logic [WB_AW-1:0] rd;
        logic [WB_DW-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_pick.sv
// Write-port grant selection between the mem (0) and ALU (1) write-back sources.
// Latency: purely combinational.
// Backpressure: at most one nonzero-rd request granted; contention resolved in favour of pref.
//
// Ports:
//   s0_req/s1_req  - source is presenting a request (already gated by reset)
//   s0_nz/s1_nz    - request targets a nonzero register (needs the write port)
//   pref           - source that wins when both nonzero requests compete
//   grant          - one-hot grant of the write port, bit N = source N
//   contend        - both sources want the write port this cycle
module wb_pick
    import wb_pkg::*;
(
    input  logic       s0_req,
    input  logic       s0_nz,
    input  logic       s1_req,
    input  logic       s1_nz,
    input  wb_src_e    pref,
    output logic [1:0] grant,
    output logic       contend
);

    logic want0;
    logic want1;

    assign want0 = s0_req && s0_nz;
    assign want1 = s1_req && s1_nz;

    always_comb begin
        grant   = 2'b00;
        contend = want0 && want1;
        if (contend) begin
            if (pref == WB_SRC_MEM) begin
                grant = 2'b01;
            end else begin
                grant = 2'b10;
            end
        end else if (want0) begin
            grant = 2'b01;
        end else if (want1) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Two-source register-file write-back arbiter (mem = source 0, ALU = source 1).
// Latency: 1 cycle from grant to wb_rd/wb_data; rd == 0 requests are accepted and dropped.
// Backpressure: sN_ready is combinational; the contention loser sees ready low and must hold.
//
// Build option: define WB_ARBITER_RR_EN for round-robin contention resolution;
// without it source 0 always wins contention.
//
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   sN_valid/rd/data     - source N request; sN_ready high when accepted this cycle
//   wb_rd, wb_data       - registered register-file write (wb_rd == 0 means no write)
//   conflict_cnt         - saturating count of cycles where both sources wanted the port
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DW = 64,
    parameter int AW = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s0_valid,
    input  logic [AW-1:0]       s0_rd,
    input  logic [DW-1:0]       s0_data,
    output logic                s0_ready,
    input  logic                s1_valid,
    input  logic [AW-1:0]       s1_rd,
    input  logic [DW-1:0]       s1_data,
    output logic                s1_ready,
    output logic [AW-1:0]       wb_rd,
    output logic [DW-1:0]       wb_data,
    output logic [WB_CNT_W-1:0] conflict_cnt
);

    logic       s0_req;
    logic       s1_req;
    logic       s0_nz;
    logic       s1_nz;
    logic [1:0] grant;
    logic       contend;
    wb_src_e    pref;

    // Requests are masked while reset is asserted so no ready or grant can
    // escape during reset.
    assign s0_req = s0_valid && rst_n;
    assign s1_req = s1_valid && rst_n;
    assign s0_nz  = (s0_rd != '0);
    assign s1_nz  = (s1_rd != '0);

`ifdef WB_ARBITER_RR_EN
    // Pointer names the source preferred at the next contention: the one
    // not granted at the most recent nonzero-rd grant, contended or not.
    wb_src_e rr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= WB_SRC_MEM;
        end else if (grant[0]) begin
            rr_ptr <= WB_SRC_ALU;
        end else if (grant[1]) begin
            rr_ptr <= WB_SRC_MEM;
        end
    end

    assign pref = rr_ptr;
`else
    assign pref = WB_SRC_MEM;
`endif

    wb_pick u_pick (
        .s0_req  (s0_req),
        .s0_nz   (s0_nz),
        .s1_req  (s1_req),
        .s1_nz   (s1_nz),
        .pref    (pref),
        .grant   (grant),
        .contend (contend)
    );

    // rd == 0 requests never need the write port, so they are always taken.
    assign s0_ready = s0_req && (!s0_nz || grant[0]);
    assign s1_ready = s1_req && (!s1_nz || grant[1]);

    // Output register: holds a write for exactly the cycle after its grant,
    // and returns to zero whenever the previous cycle had no grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_rd   <= '0;
            wb_data <= '0;
        end else if (grant[0]) begin
            wb_rd   <= s0_rd;
            wb_data <= s0_data;
        end else if (grant[1]) begin
            wb_rd   <= s1_rd;
            wb_data <= s1_data;
        end else begin
            wb_rd   <= '0;
            wb_data <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (contend && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

endmodule
